// File: rtl/xmtr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xmtr_pkg
//  Description : Shared definitions for the serial frame transmitter and its
//                receiver partner: frame header pattern, frame field sizes
//                and the transmitter state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package xmtr_pkg;

    // Header pattern; the receiver hard-codes the same match value.
    localparam logic [7:0] HEADER          = 8'hA5;
    localparam int         FRAME_HDR_BITS  = 8;
    localparam int         FRAME_BODY_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2,
        ST_GAP  = 2'd3
    } xmtr_state_e;

endpackage : xmtr_pkg
`default_nettype wire

// File: rtl/xmtr_if.sv
`default_nettype none
// ============================================================================
//  Module      : xmtr_if
//  Description : Parallel write port and serial line bundle of the frame
//                transmitter.
//                  data_in    - byte to transmit (writer -> xmtr)
//                  load       - write strobe     (writer -> xmtr)
//                  ready      - holding buffer empty
//                  overflow   - sticky, load seen while not ready
//                  serial_out - serial line
//                  active     - header/body bit on the line
//                  sent       - pulse with body bit 0 on the line
//  Revision    : 1.0 - initial release
// ============================================================================
interface xmtr_if;
    logic [7:0] data_in;
    logic       load;
    logic       ready;
    logic       overflow;
    logic       serial_out;
    logic       active;
    logic       sent;

    modport master (
        output data_in, load,
        input  ready, overflow, serial_out, active, sent
    );

    modport slave (
        input  data_in, load,
        output ready, overflow, serial_out, active, sent
    );
endinterface : xmtr_if
`default_nettype wire

// File: rtl/xmtr.sv
`default_nettype none
// ============================================================================
//  Module      : xmtr
//  Description : Serial frame transmitter. A byte written into a one-entry
//                holding buffer goes out as a 16-bit frame (header, then
//                body, both MSB first, one bit per clock). Line idles low.
//  Ports       : clock - rising-edge clock
//                reset - synchronous, active-high
//                bus   - xmtr_if.slave (write port + serial line outputs)
//  Parameters  : HEADER   - frame header pattern
//                IDLE_GAP - forced low bits between frames (0..15)
//  Revision    : 1.0 - initial release
// ============================================================================
module xmtr #(
    parameter logic [7:0] HEADER   = xmtr_pkg::HEADER,
    parameter int         IDLE_GAP = 0
) (
    input  wire    clock,
    input  wire    reset,
    xmtr_if.slave  bus
);
    import xmtr_pkg::*;

    // Index of the bit driven on the edge after the first one of a field.
    localparam logic [3:0] c_BIT_TOP  = 4'(FRAME_HDR_BITS - 2);
    // Gap counter preload: the counter reaching 0 marks the last gap bit.
    localparam logic [3:0] c_GAP_LOAD = 4'((IDLE_GAP == 0) ? 0 : IDLE_GAP - 1);

    xmtr_state_e state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  buf_q, buf_d;
    logic        full_q, full_d;
    logic        overflow_q, overflow_d;
    logic        serial_q, serial_d;
    logic        active_q, active_d;
    logic        sent_q, sent_d;
    logic        start_frame;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= 4'd0;
            shreg_q    <= 8'd0;
            buf_q      <= 8'd0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            serial_q   <= 1'b0;
            active_q   <= 1'b0;
            sent_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            buf_q      <= buf_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            serial_q   <= serial_d;
            active_q   <= active_d;
            sent_q     <= sent_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        buf_d       = buf_q;
        full_d      = full_q;
        overflow_d  = overflow_q;
        serial_d    = serial_q;
        active_d    = active_q;
        sent_d      = 1'b0;
        start_frame = 1'b0;

        // Holding buffer write. Acceptance uses the pre-edge full flag, so a
        // load on the edge that empties the buffer is still rejected.
        if (bus.load) begin
            if (!full_q) begin
                buf_d  = bus.data_in;
                full_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end

        // idx counts down through a field; wrapping to 4'hF (bit 3 set)
        // marks that bit 0 of the field is currently on the line.
        case (state_q)
            ST_IDLE: begin
                serial_d    = 1'b0;
                active_d    = 1'b0;
                start_frame = full_q;
            end
            ST_HEAD: begin
                if (idx_q[3]) begin
                    state_d  = ST_BODY;
                    serial_d = shreg_q[7];
                    idx_d    = c_BIT_TOP;
                end else begin
                    serial_d = HEADER[idx_q[2:0]];
                    idx_d    = idx_q - 4'd1;
                end
            end
            ST_BODY: begin
                if (idx_q[3]) begin
                    if (IDLE_GAP > 0) begin
                        state_d  = ST_GAP;
                        serial_d = 1'b0;
                        active_d = 1'b0;
                        idx_d    = c_GAP_LOAD;
                    end else if (full_q) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        serial_d = 1'b0;
                        active_d = 1'b0;
                    end
                end else begin
                    serial_d = shreg_q[idx_q[2:0]];
                    sent_d   = (idx_q == 4'd0);
                    idx_d    = idx_q - 4'd1;
                end
            end
            ST_GAP: begin
                serial_d = 1'b0;
                active_d = 1'b0;
                if (idx_q == 4'd0) begin
                    state_d     = ST_IDLE;
                    start_frame = full_q;
                end else begin
                    idx_d = idx_q - 4'd1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                serial_d = 1'b0;
                active_d = 1'b0;
            end
        endcase

        // Move the buffered byte into the shifter and put HEADER[7] out.
        if (start_frame) begin
            shreg_d  = buf_q;
            full_d   = 1'b0;
            state_d  = ST_HEAD;
            serial_d = HEADER[7];
            active_d = 1'b1;
            idx_d    = c_BIT_TOP;
        end
    end

    assign bus.ready      = !full_q;
    assign bus.overflow   = overflow_q;
    assign bus.serial_out = serial_q;
    assign bus.active     = active_q;
    assign bus.sent       = sent_q;

endmodule : xmtr
`default_nettype wire

// File: tb/tb_xmtr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xmtr
//  Description : Bench for xmtr. Two instances (IDLE_GAP 0 and 3) share one
//                write stimulus. A schedule-level model predicts buffer
//                occupancy, frame start edges and overflow; expected frames
//                are queued on acceptance and popped when sent pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xmtr;
    import xmtr_pkg::*;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       load    = 1'b0;
    logic [7:0] data_in = 8'h00;

    always #5 clock = ~clock;

    xmtr_if bus0 ();
    xmtr_if bus3 ();

    assign bus0.load    = load;
    assign bus0.data_in = data_in;
    assign bus3.load    = load;
    assign bus3.data_in = data_in;

    xmtr #(.HEADER(8'hA5), .IDLE_GAP(0)) dut0 (.clock(clock), .reset(reset), .bus(bus0));
    xmtr #(.HEADER(8'hA5), .IDLE_GAP(3)) dut3 (.clock(clock), .reset(reset), .bus(bus3));

    typedef struct {
        logic [7:0] d;
        int         c;   // edge after which sent must be high
    } exp_t;

    exp_t        sb [2][$];
    int          cyc      = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        m_full  [2];
    logic        m_ovf   [2];
    int          m_busy  [2];   // first edge the FSM can take a new byte
    int          m_start [2];   // edge that put the current frame's HEADER[7] out
    int          m_drain [2];
    logic [15:0] hist    [2];

    function automatic int gap_of(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    task automatic chk(input string name, input int inst, input logic [15:0] got,
                       input logic [15:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s gap%0d cycle %0d: got %h, want %h", name, gap_of(inst), cyc, got, want);
        end
    endtask

    // Reference model: one-entry buffer, frames of 16 bits plus the gap.
    initial begin
        forever begin
            @(posedge clock);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                logic pre;
                if (reset) begin
                    m_full[i]  = 1'b0;
                    m_ovf[i]   = 1'b0;
                    m_busy[i]  = 0;
                    m_start[i] = -100;
                    m_drain[i] = 0;
                    sb[i].delete();
                end else begin
                    pre = m_full[i];
                    if (m_full[i] && cyc == m_drain[i]) begin
                        m_full[i]  = 1'b0;
                        m_start[i] = cyc;
                        m_busy[i]  = cyc + 16 + gap_of(i);
                    end
                    if (load) begin
                        if (!pre) begin
                            m_full[i]  = 1'b1;
                            m_drain[i] = (cyc + 1 > m_busy[i]) ? cyc + 1 : m_busy[i];
                            sb[i].push_back('{data_in, m_drain[i] + 15});
                        end else begin
                            m_ovf[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Monitor: per-cycle status checks and frame comparison on sent.
    initial begin
        forever begin
            @(negedge clock);
            if (cyc >= 1) begin
                for (int i = 0; i < 2; i++) begin
                    logic sv, act, rdy, ovf, snt, exp_act;
                    exp_t e;
                    sv  = (i == 0) ? bus0.serial_out : bus3.serial_out;
                    act = (i == 0) ? bus0.active     : bus3.active;
                    rdy = (i == 0) ? bus0.ready      : bus3.ready;
                    ovf = (i == 0) ? bus0.overflow   : bus3.overflow;
                    snt = (i == 0) ? bus0.sent       : bus3.sent;
                    hist[i] = {hist[i][14:0], sv};
                    exp_act = (cyc >= m_start[i]) && (cyc <= m_start[i] + 15);
                    chk("ready", i, 16'(rdy), 16'(!m_full[i]));
                    chk("overflow", i, 16'(ovf), 16'(m_ovf[i]));
                    chk("active", i, 16'(act), 16'(exp_act));
                    if (!exp_act)
                        chk("idle_line", i, 16'(sv), 16'd0);
                    if (snt) begin
                        if (sb[i].size() == 0) begin
                            chk("unexpected_sent", i, 16'd1, 16'd0);
                        end else begin
                            e = sb[i].pop_front();
                            chk("sent_cycle", i, 16'(cyc), 16'(e.c));
                            chk("frame", i, hist[i], {HEADER, e.d});
                        end
                    end else if (sb[i].size() > 0 && sb[i][0].c < cyc) begin
                        e = sb[i].pop_front();
                        chk("missing_sent", i, 16'(e.d), 16'hFFFF);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send(input logic [7:0] d);
        load    = 1'b1;
        data_in = d;
        @(negedge clock);
        load    = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while ((m_full[0] || m_full[1]) && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100)
            chk("wait_ready_timeout", 0, 16'(n), 16'd0);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        idle(20);

        send(8'h3C);
        idle(25);

        send(8'hFF);
        wait_ready();
        send(8'h00);
        idle(45);

        send(8'h81);
        wait_ready();
        send(8'h7E);
        idle(45);

        send(8'h11);
        wait_ready();
        send(8'h22);
        send(8'h33);
        idle(45);

        // Reset while HEADER[4] is on the line, then a clean frame.
        send(8'hC3);
        idle(4);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        send(8'h5A);
        idle(25);

        for (int k = 0; k < 1500; k++) begin
            reset   = ($urandom_range(0, 299) == 0);
            load    = ($urandom_range(0, 3) == 0);
            data_in = 8'($urandom);
            @(negedge clock);
        end
        reset = 1'b0;
        load  = 1'b0;
        idle(60);

        for (int i = 0; i < 2; i++)
            chk("scoreboard_empty", i, 16'(sb[i].size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_xmtr
`default_nettype wire
